micro_sequencer: RTL and testbench

Micro-fetch/decode stage sitting directly upstream of mdecode_reg. Holds the micro-PC and fetches 32-bit microwords from the microcode ROM over a req/valid interface. Decodes each microword into the *_md field and control signals consumed by mdecode_reg, and resolves micro-branches (unconditional and on ALU zero). Runs from a dispatched entry address until a HALT microword.

---
 rtl/micro_sequencer_if.sv | 49 ++++
 rtl/micro_sequencer.sv | 165 ++++++++++++++++
 tb/tb_micro_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// Bundle between the micro-sequencer, the microcode ROM and mdecode_reg.
// Carries the ROM req/valid fetch bus and the registered *_md decode fields.
// master = sequencer side, slave = ROM / decode-register side.
interface micro_sequencer_if #(
  parameter int UADDR_WIDTH    = 10,
  parameter int UWORD_WIDTH    = 32,
  parameter int IMM_WIDTH      = 11,
  parameter int ALU_OPS        = 8,
  parameter int REG_ADDR_WIDTH = 4
);
  localparam int ALU_OP_WIDTH = $clog2(ALU_OPS);

  // ROM fetch bus
  logic                      rom_req;
  logic [UADDR_WIDTH-1:0]    rom_addr;
  logic [UWORD_WIDTH-1:0]    rom_rdata;
  logic                      rom_valid;

  // decoded microword towards mdecode_reg
  logic                      md_valid;
  logic [REG_ADDR_WIDTH-1:0] reg_src_md;
  logic [REG_ADDR_WIDTH-1:0] reg_dst_md;
  logic [IMM_WIDTH-1:0]      imm_md;
  logic [UADDR_WIDTH-1:0]    branch_target_md;
  logic                      is_imm_active_md;
  logic                      alu_en_md;
  logic                      reg_file_en_md;
  logic                      reg_file_rw_md;
  logic                      mem_en_md;
  logic                      mem_rw_md;
  logic                      is_branch_md;
  logic [ALU_OP_WIDTH-1:0]   alu_op_md;

  modport master (
    output rom_req, rom_addr,
    input  rom_rdata, rom_valid,
    output md_valid, reg_src_md, reg_dst_md, imm_md, branch_target_md,
    output is_imm_active_md, alu_en_md, reg_file_en_md, reg_file_rw_md,
    output mem_en_md, mem_rw_md, is_branch_md, alu_op_md
  );

  modport slave (
    input  rom_req, rom_addr,
    output rom_rdata, rom_valid,
    input  md_valid, reg_src_md, reg_dst_md, imm_md, branch_target_md,
    input  is_imm_active_md, alu_en_md, reg_file_en_md, reg_file_rw_md,
    input  mem_en_md, mem_rw_md, is_branch_md, alu_op_md
  );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-fetch/decode: holds the micro-PC, fetches microwords, decodes them for mdecode_reg.
// Latency: start -> rom_req next cycle; rom_valid -> md_valid next cycle; one FETCH per microword.
// Backpressure: pipe_stall holds ISSUE with all outputs and upc frozen; no ROM request while stalled.
module micro_sequencer #(
  parameter int UADDR_WIDTH    = 10,
  parameter int UWORD_WIDTH    = 32,
  parameter int IMM_WIDTH      = 11,
  parameter int ALU_OPS        = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset,
  input  logic                   start,
  input  logic [UADDR_WIDTH-1:0] entry_addr,
  input  logic                   pipe_stall,
  input  logic                   alu_zero,
  micro_sequencer_if.master      bus,
  output logic                   halted,
  output logic                   illegal,
  output logic [UADDR_WIDTH-1:0] upc
);
  localparam int ALU_OP_WIDTH = $clog2(ALU_OPS);

  localparam logic [3:0] MOP_NOP    = 4'd0;
  localparam logic [3:0] MOP_ALU_R  = 4'd1;
  localparam logic [3:0] MOP_ALU_I  = 4'd2;
  localparam logic [3:0] MOP_LOAD   = 4'd3;
  localparam logic [3:0] MOP_STORE  = 4'd4;
  localparam logic [3:0] MOP_REG_RD = 4'd5;
  localparam logic [3:0] MOP_REG_WR = 4'd6;
  localparam logic [3:0] MOP_BR     = 4'd7;
  localparam logic [3:0] MOP_BRZ    = 4'd8;
  localparam logic [3:0] MOP_HALT   = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE} state_t;

  state_t state;
  logic   br_q, brz_q, halt_q;
  logic   branch_taken;

  // microword fields
  logic [3:0] w_mop;
  logic       reserved_unused;
  assign w_mop           = bus.rom_rdata[UWORD_WIDTH-1 -: 4];
  assign reserved_unused = ^bus.rom_rdata[16:11];

  // decoded controls of the word currently on rom_rdata
  logic d_alu_en, d_imm, d_rf_en, d_rf_rw, d_mem_en, d_mem_rw;
  logic d_br, d_brz, d_halt, d_illegal;

  // BRZ follows alu_zero live while the word is issued
  assign branch_taken     = br_q | (brz_q & alu_zero);
  assign bus.is_branch_md = (state == S_ISSUE) & branch_taken;
  assign bus.rom_addr     = upc;

  // mop decode; undefined opcodes behave as NOP and raise illegal
  always_comb begin
    d_alu_en  = 1'b0;
    d_imm     = 1'b0;
    d_rf_en   = 1'b0;
    d_rf_rw   = 1'b0;
    d_mem_en  = 1'b0;
    d_mem_rw  = 1'b0;
    d_br      = 1'b0;
    d_brz     = 1'b0;
    d_halt    = 1'b0;
    d_illegal = 1'b0;
    case (w_mop)
      MOP_NOP:    ;
      MOP_ALU_R:  begin d_alu_en = 1'b1; d_rf_en = 1'b1; end
      MOP_ALU_I:  begin d_alu_en = 1'b1; d_imm = 1'b1; end
      MOP_LOAD:   begin d_mem_en = 1'b1; d_rf_en = 1'b1; d_rf_rw = 1'b1; end
      MOP_STORE:  begin d_mem_en = 1'b1; d_mem_rw = 1'b1; d_rf_en = 1'b1; end
      MOP_REG_RD: d_rf_en = 1'b1;
      MOP_REG_WR: begin d_rf_en = 1'b1; d_rf_rw = 1'b1; d_imm = 1'b1; end
      MOP_BR:     d_br = 1'b1;
      MOP_BRZ:    d_brz = 1'b1;
      MOP_HALT:   d_halt = 1'b1;
      default:    d_illegal = 1'b1;
    endcase
  end

  // sequencer FSM with registered decode outputs and micro-PC
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state                <= S_IDLE;
      upc                  <= '0;
      halted               <= 1'b0;
      illegal              <= 1'b0;
      br_q                 <= 1'b0;
      brz_q                <= 1'b0;
      halt_q               <= 1'b0;
      bus.rom_req          <= 1'b0;
      bus.md_valid         <= 1'b0;
      bus.reg_src_md       <= '0;
      bus.reg_dst_md       <= '0;
      bus.imm_md           <= '0;
      bus.branch_target_md <= '0;
      bus.alu_op_md        <= '0;
      bus.is_imm_active_md <= 1'b0;
      bus.alu_en_md        <= 1'b0;
      bus.reg_file_en_md   <= 1'b0;
      bus.reg_file_rw_md   <= 1'b0;
      bus.mem_en_md        <= 1'b0;
      bus.mem_rw_md        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            upc         <= entry_addr;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            bus.rom_req <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          bus.rom_req <= 1'b0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.rom_valid) begin
            bus.reg_dst_md       <= bus.rom_rdata[24 +: REG_ADDR_WIDTH];
            bus.reg_src_md       <= bus.rom_rdata[20 +: REG_ADDR_WIDTH];
            bus.alu_op_md        <= bus.rom_rdata[17 +: ALU_OP_WIDTH];
            bus.imm_md           <= bus.rom_rdata[IMM_WIDTH-1:0];
            bus.branch_target_md <= bus.rom_rdata[UADDR_WIDTH-1:0];
            bus.is_imm_active_md <= d_imm;
            bus.reg_file_rw_md   <= d_rf_rw;
            bus.mem_rw_md        <= d_mem_rw;
            bus.alu_en_md        <= d_alu_en;
            bus.reg_file_en_md   <= d_rf_en;
            bus.mem_en_md        <= d_mem_en;
            bus.md_valid         <= 1'b1;
            br_q                 <= d_br;
            brz_q                <= d_brz;
            halt_q               <= d_halt;
            if (d_illegal) illegal <= 1'b1;
            state                <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!pipe_stall) begin
            bus.md_valid       <= 1'b0;
            bus.alu_en_md      <= 1'b0;
            bus.reg_file_en_md <= 1'b0;
            bus.mem_en_md      <= 1'b0;
            br_q               <= 1'b0;
            brz_q              <= 1'b0;
            halt_q             <= 1'b0;
            upc                <= branch_taken ? bus.branch_target_md : upc + 1'b1;
            if (halt_q) begin
              halted <= 1'b1;
              state  <= S_IDLE;
            end else begin
              bus.rom_req <= 1'b1;
              state       <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: ROM responder with fixed 2-cycle latency,
// a microprogram exercising ALU_I, BR, wrap, BRZ, stalled LOAD, HALT, illegal and reset-in-WAIT.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_micro_sequencer;
  logic       sys_clk;
  logic       sys_reset;
  logic       start;
  logic [9:0] entry_addr;
  logic       pipe_stall;
  logic       alu_zero;
  logic       halted;
  logic       illegal;
  logic [9:0] upc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rom [0:1023];
  logic [9:0]  rsp_addr;

  micro_sequencer_if bus ();

  micro_sequencer dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .start      (start),
    .entry_addr (entry_addr),
    .pipe_stall (pipe_stall),
    .alu_zero   (alu_zero),
    .bus        (bus),
    .halted     (halted),
    .illegal    (illegal),
    .upc        (upc)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic logic [31:0] mk(input logic [3:0] mop, input logic [3:0] dst,
                                     input logic [3:0] src, input logic [2:0] op,
                                     input logic [10:0] imm);
    return {mop, dst, src, op, 6'b101010, imm};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] addr);
    @(posedge sys_clk);
    #1 start = 1'b1;
    entry_addr = addr;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sys_clk);
      if (bus.md_valid) seen = 1'b1;
    end
    check_eq({tag, " issue seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_fetch(input string tag, input logic [9:0] exp_addr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sys_clk);
      if (bus.rom_req) seen = 1'b1;
    end
    check_eq({tag, " fetch seen"}, 32'(seen), 32'd1);
    check_eq({tag, " rom_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
  endtask

  // ROM model: answers every request two cycles after rom_req
  initial begin
    bus.rom_valid = 1'b0;
    bus.rom_rdata = '0;
    forever begin
      @(negedge sys_clk);
      if (bus.rom_req) begin
        rsp_addr = bus.rom_addr;
        repeat (2) @(posedge sys_clk);
        #1 bus.rom_rdata = rom[rsp_addr];
        bus.rom_valid = 1'b1;
        @(posedge sys_clk);
        #1 bus.rom_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    rom[10'h010] = mk(4'd2, 4'd5, 4'd9, 3'd3, 11'h155);  // ALU_I
    rom[10'h011] = mk(4'd7, 4'd0, 4'd0, 3'd0, 11'h020);  // BR 0x020
    rom[10'h020] = mk(4'd7, 4'd0, 4'd0, 3'd0, 11'h3F0);  // BR 0x3F0
    rom[10'h3F0] = mk(4'd7, 4'd0, 4'd0, 3'd0, 11'h3FF);  // BR 0x3FF
    rom[10'h3FF] = mk(4'd0, 4'd0, 4'd0, 3'd0, 11'h000);  // NOP -> wrap
    rom[10'h000] = mk(4'd7, 4'd0, 4'd0, 3'd0, 11'h030);  // BR 0x030
    rom[10'h030] = mk(4'd8, 4'd0, 4'd0, 3'd0, 11'h050);  // BRZ 0x050
    rom[10'h031] = mk(4'd7, 4'd0, 4'd0, 3'd0, 11'h030);  // BR 0x030
    rom[10'h050] = mk(4'd3, 4'd7, 4'd2, 3'd0, 11'h000);  // LOAD
    rom[10'h051] = mk(4'd7, 4'd0, 4'd0, 3'd0, 11'h040);  // BR 0x040
    rom[10'h040] = mk(4'd9, 4'd0, 4'd0, 3'd0, 11'h000);  // HALT
    rom[10'h041] = mk(4'hC, 4'd3, 4'd4, 3'd5, 11'h2AA);  // undefined
    rom[10'h042] = mk(4'd9, 4'd0, 4'd0, 3'd0, 11'h000);  // HALT
    rom[10'h060] = mk(4'd2, 4'd1, 4'd1, 3'd1, 11'h001);  // ALU_I

    sys_reset = 1'b0; start = 1'b0; entry_addr = '0; pipe_stall = 1'b0; alu_zero = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_eq("reset md_valid", 32'(bus.md_valid), 32'd0);
    check_eq("reset rom_req", 32'(bus.rom_req), 32'd0);
    check_eq("reset upc", 32'(upc), 32'd0);
    check_eq("reset halted", 32'(halted), 32'd0);
    check_eq("reset imm_md", 32'(bus.imm_md), 32'd0);
    @(posedge sys_clk);
    #1 sys_reset = 1'b1;

    // ALU_I at 0x010
    do_start(10'h010);
    wait_fetch("alui", 10'h010);
    wait_issue("alui");
    check_eq("alui alu_en", 32'(bus.alu_en_md), 32'd1);
    check_eq("alui is_imm", 32'(bus.is_imm_active_md), 32'd1);
    check_eq("alui alu_op", 32'(bus.alu_op_md), 32'd3);
    check_eq("alui imm", 32'(bus.imm_md), 32'h155);
    check_eq("alui reg_dst", 32'(bus.reg_dst_md), 32'd5);
    check_eq("alui reg_src", 32'(bus.reg_src_md), 32'd9);
    check_eq("alui reg_file_en", 32'(bus.reg_file_en_md), 32'd0);
    check_eq("alui rom_req", 32'(bus.rom_req), 32'd0);
    wait_fetch("after alui", 10'h011);
    check_eq("fetch md_valid", 32'(bus.md_valid), 32'd0);
    check_eq("fetch alu_en", 32'(bus.alu_en_md), 32'd0);
    check_eq("fetch imm held", 32'(bus.imm_md), 32'h155);

    // unconditional branches and wrap
    wait_issue("br 011");
    wait_fetch("br 011", 10'h020);
    wait_issue("br 020");
    check_eq("br is_branch", 32'(bus.is_branch_md), 32'd1);
    check_eq("br target", 32'(bus.branch_target_md), 32'h3F0);
    wait_fetch("br 020", 10'h3F0);
    wait_issue("br 3f0");
    wait_fetch("br 3f0", 10'h3FF);
    wait_issue("nop 3ff");
    check_eq("nop is_branch", 32'(bus.is_branch_md), 32'd0);
    check_eq("nop alu_en", 32'(bus.alu_en_md), 32'd0);
    check_eq("nop reg_file_en", 32'(bus.reg_file_en_md), 32'd0);
    wait_fetch("wrap", 10'h000);
    wait_issue("br 000");
    wait_fetch("br 000", 10'h030);

    // BRZ not taken, then taken
    wait_issue("brz z0");
    check_eq("brz z0 is_branch", 32'(bus.is_branch_md), 32'd0);
    wait_fetch("brz z0", 10'h031);
    alu_zero = 1'b1;
    wait_issue("br 031");
    wait_fetch("br 031", 10'h030);
    wait_issue("brz z1");
    check_eq("brz z1 is_branch", 32'(bus.is_branch_md), 32'd1);
    wait_fetch("brz z1", 10'h050);
    alu_zero = 1'b0;

    // LOAD held by a 3-cycle stall
    pipe_stall = 1'b1;
    wait_issue("load");
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("load c%0d md_valid", c), 32'(bus.md_valid), 32'd1);
      check_eq($sformatf("load c%0d mem_en", c), 32'(bus.mem_en_md), 32'd1);
      check_eq($sformatf("load c%0d mem_rw", c), 32'(bus.mem_rw_md), 32'd0);
      check_eq($sformatf("load c%0d rf_en", c), 32'(bus.reg_file_en_md), 32'd1);
      check_eq($sformatf("load c%0d rf_rw", c), 32'(bus.reg_file_rw_md), 32'd1);
      check_eq($sformatf("load c%0d reg_dst", c), 32'(bus.reg_dst_md), 32'd7);
      check_eq($sformatf("load c%0d upc", c), 32'(upc), 32'h050);
      check_eq($sformatf("load c%0d rom_req", c), 32'(bus.rom_req), 32'd0);
      if (c < 3) begin
        @(posedge sys_clk);
        #1 if (c == 2) pipe_stall = 1'b0;
        @(negedge sys_clk);
      end
    end
    @(negedge sys_clk);
    check_eq("post stall rom_req", 32'(bus.rom_req), 32'd1);
    check_eq("post stall rom_addr", 32'(bus.rom_addr), 32'h051);
    wait_issue("br 051");
    wait_fetch("br 051", 10'h040);

    // HALT, with a start pulse during ISSUE that must be ignored
    wait_issue("halt 040");
    start = 1'b1;
    entry_addr = 10'h123;
    @(posedge sys_clk);
    #1 start = 1'b0;
    @(negedge sys_clk);
    check_eq("halt halted", 32'(halted), 32'd1);
    check_eq("halt upc", 32'(upc), 32'h041);
    check_eq("halt md_valid", 32'(bus.md_valid), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.rom_req) quiet = 1'b0;
      @(negedge sys_clk);
    end
    check_eq("halt idle no req", 32'(quiet), 32'd1);
    check_eq("halt upc kept", 32'(upc), 32'h041);

    // undefined opcode after restart
    do_start(10'h041);
    wait_fetch("illegal", 10'h041);
    check_eq("restart halted", 32'(halted), 32'd0);
    wait_issue("illegal");
    check_eq("illegal alu_en", 32'(bus.alu_en_md), 32'd0);
    check_eq("illegal rf_en", 32'(bus.reg_file_en_md), 32'd0);
    check_eq("illegal mem_en", 32'(bus.mem_en_md), 32'd0);
    check_eq("illegal is_branch", 32'(bus.is_branch_md), 32'd0);
    check_eq("illegal is_imm", 32'(bus.is_imm_active_md), 32'd0);
    check_eq("illegal rf_rw", 32'(bus.reg_file_rw_md), 32'd0);
    check_eq("illegal mem_rw", 32'(bus.mem_rw_md), 32'd0);
    wait_fetch("illegal next", 10'h042);
    check_eq("illegal flag", 32'(illegal), 32'd1);
    wait_issue("halt 042");
    @(negedge sys_clk);
    check_eq("halt2 halted", 32'(halted), 32'd1);
    check_eq("halt2 illegal", 32'(illegal), 32'd1);
    check_eq("halt2 upc", 32'(upc), 32'h043);

    // new start clears both sticky flags
    do_start(10'h040);
    wait_fetch("clear", 10'h040);
    check_eq("clear halted", 32'(halted), 32'd0);
    check_eq("clear illegal", 32'(illegal), 32'd0);
    wait_issue("halt 040b");
    @(negedge sys_clk);
    check_eq("halt3 halted", 32'(halted), 32'd1);

    // reset while waiting on the ROM; late response must be dropped
    do_start(10'h060);
    wait_fetch("rst", 10'h060);
    @(posedge sys_clk);
    #1 sys_reset = 1'b0;
    @(negedge sys_clk);
    check_eq("rst upc", 32'(upc), 32'd0);
    check_eq("rst halted", 32'(halted), 32'd0);
    check_eq("rst rom_req", 32'(bus.rom_req), 32'd0);
    @(posedge sys_clk);
    #1 sys_reset = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      if (bus.md_valid || bus.rom_req) quiet = 1'b0;
    end
    check_eq("rst dropped rsp", 32'(quiet), 32'd1);
    check_eq("rst upc idle", 32'(upc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
